adata_buf_arbiter: RTL and testbench

//  Arbitrates one single-port audio sample RAM between the ADC sample writer and the

---
 rtl/adata_buf_arbiter.sv | 173 +++++++++++++++++
 tb/tb_adata_buf_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/adata_buf_arbiter.sv
// Shares one single-port sample RAM: read bursts (priority) vs FIFO-buffered ADC writes.
// Read data 2 cycles after address; writes stall during bursts, samples dropped (OVF) on full FIFO.
module adata_buf_arbiter #(
  parameter int ABIT      = 12,
  parameter int DW        = 18,
  parameter int BURST_LEN = 1024,
  parameter int LAG       = 1024,
  parameter int FABIT     = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [DW-1:0]   ADATA,
  input  logic            ADATARDY,
  input  logic            RD_START,
  output logic [DW-1:0]   RD_DATA,
  output logic            RD_VALID,
  output logic            RD_LAST,
  output logic            BUSY,
  output logic [ABIT-1:0] WPTR,
  output logic            OVF,
  output logic [ABIT-1:0] RAM_ADDR,
  output logic            RAM_WE,
  output logic [DW-1:0]   RAM_WDATA,
  input  logic [DW-1:0]   RAM_RDATA
);

  localparam int              FDEPTH = 2**FABIT;
  localparam logic [ABIT:0]   LEN    = (ABIT+1)'(BURST_LEN);
  localparam logic [ABIT-1:0] LAG_A  = ABIT'(LAG);
  localparam logic [FABIT:0]  FULL   = (FABIT+1)'(FDEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [ABIT:0]   cnt_q, cnt_d;
  logic            re_q, re_d, last_q, last_d;
  logic            re1_q, re1_d, last1_q, last1_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [ABIT-1:0] wptr_q, wptr_d, ram_addr_q, ram_addr_d;
  logic            ram_we_q, ram_we_d, ovf_q, ovf_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DW-1:0]   mem_q [FDEPTH];
  logic [DW-1:0]   mem_d [FDEPTH];
  logic [FABIT-1:0] rdp_q, rdp_d, wrp_q, wrp_d;
  logic [FABIT:0]  count_q, count_d;
  logic            wslot, pop, fifo_pop, push;
  logic [DW-1:0]   head;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    re_d        = 1'b0;
    last_d      = 1'b0;
    re1_d       = re_q;
    last1_d     = last_q;
    rd_valid_d  = re1_q;
    rd_last_d   = last1_q;
    rd_data_d   = re1_q ? RAM_RDATA : rd_data_q;
    wptr_d      = wptr_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    ovf_d       = ovf_q;
    mem_d       = mem_q;
    rdp_d       = rdp_q;
    wrp_d       = wrp_q;
    count_d     = count_q;
    wslot       = 1'b0;

    case (state_q)
      IDLE: begin
        if (RD_START) begin
          state_d    = BURST;
          ram_addr_d = wptr_q - LAG_A;
          cnt_d      = (ABIT+1)'(1);
          re_d       = 1'b1;
          last_d     = (LEN == (ABIT+1)'(1));
        end else begin
          wslot = 1'b1;
        end
      end
      BURST: begin
        // The edge after the final address both leaves the burst and may already write.
        if (cnt_q == LEN) begin
          state_d = IDLE;
          cnt_d   = '0;
          wslot   = 1'b1;
        end else begin
          ram_addr_d = ram_addr_q + ABIT'(1);
          cnt_d      = cnt_q + (ABIT+1)'(1);
          re_d       = 1'b1;
          last_d     = ((cnt_q + (ABIT+1)'(1)) == LEN);
        end
      end
      default: state_d = IDLE;
    endcase

    // An empty FIFO forwards the incoming sample straight to the RAM port.
    head     = (count_q != '0) ? mem_q[rdp_q] : ADATA;
    pop      = wslot && ((count_q != '0) || ADATARDY);
    fifo_pop = pop && (count_q != '0);
    push     = ADATARDY && !(pop && !fifo_pop) && ((count_q != FULL) || pop);

    if (ADATARDY && (count_q == FULL) && !pop) ovf_d = 1'b1;

    if (pop) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = wptr_q;
      ram_wdata_d = head;
      wptr_d      = wptr_q + ABIT'(1);
    end
    if (push) begin
      mem_d[wrp_q] = ADATA;
      wrp_d        = wrp_q + FABIT'(1);
    end
    if (fifo_pop) rdp_d = rdp_q + FABIT'(1);
    count_d = count_q + {{FABIT{1'b0}}, push} - {{FABIT{1'b0}}, fifo_pop};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      re_q        <= 1'b0;
      last_q      <= 1'b0;
      re1_q       <= 1'b0;
      last1_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      wptr_q      <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      ovf_q       <= 1'b0;
      rdp_q       <= '0;
      wrp_q       <= '0;
      count_q     <= '0;
      for (int i = 0; i < FDEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      re_q        <= re_d;
      last_q      <= last_d;
      re1_q       <= re1_d;
      last1_q     <= last1_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      wptr_q      <= wptr_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      ovf_q       <= ovf_d;
      rdp_q       <= rdp_d;
      wrp_q       <= wrp_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_LAST   = rd_last_q;
  assign BUSY      = (state_q == BURST) || re1_q || rd_valid_q;
  assign WPTR      = wptr_q;
  assign OVF       = ovf_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WE    = ram_we_q;
  assign RAM_WDATA = ram_wdata_q;

endmodule

// File: tb/tb_adata_buf_arbiter.sv
// Bench for adata_buf_arbiter: cycle-level queue model of the arbiter plus a RAM model.
module tb_adata_buf_arbiter;
  localparam int ABIT = 12;
  localparam int DW = 18;
  localparam int BL = 8;
  localparam int LAG = 4;
  localparam int FABIT = 2;
  localparam int RDEPTH = 1 << ABIT;
  localparam int FDEPTH = 1 << FABIT;

  logic            CLK, RST;
  logic [DW-1:0]   ADATA;
  logic            ADATARDY, RD_START;
  logic [DW-1:0]   RD_DATA;
  logic            RD_VALID, RD_LAST, BUSY, OVF, RAM_WE;
  logic [ABIT-1:0] WPTR, RAM_ADDR;
  logic [DW-1:0]   RAM_WDATA, ram_rdata;

  adata_buf_arbiter #(.ABIT(ABIT), .DW(DW), .BURST_LEN(BL), .LAG(LAG), .FABIT(FABIT)) dut (
    .CLK(CLK), .RST(RST), .ADATA(ADATA), .ADATARDY(ADATARDY), .RD_START(RD_START),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_LAST(RD_LAST), .BUSY(BUSY), .WPTR(WPTR),
    .OVF(OVF), .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(ram_rdata)
  );

  typedef struct {
    int            cyc;
    int            addr;
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] ram [RDEPTH];
  logic [DW-1:0] gm  [RDEPTH];
  logic [DW-1:0] pend [$];
  exp_t wq [$];
  exp_t rq [$];
  int t = 0;
  int bst = -1000000;
  int m_wptr = 0;
  logic m_ovf = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, t);
    end
  endtask

  // Single-port RAM, one cycle read latency.
  always @(posedge CLK) begin
    if (RAM_WE) ram[RAM_ADDR] <= RAM_WDATA;
    ram_rdata <= ram[RAM_ADDR];
  end

  // Reference model: a capacity-limited sample queue and a burst time window.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend.delete();
      wq.delete();
      rq.delete();
      m_wptr = 0;
      m_ovf  = 1'b0;
      bst    = -1000000;
    end else begin
      bit acc, wslot;
      exp_t e;
      int s;
      t = t + 1;
      acc   = RD_START && (t > bst + BL);
      wslot = !acc && (t >= bst + BL);
      if (acc) begin
        bst = t;
        s = (m_wptr - LAG + RDEPTH) % RDEPTH;
        for (int i = 0; i < BL; i++) begin
          e.cyc = t + 2 + i; e.addr = (s + i) % RDEPTH;
          e.d = gm[e.addr]; e.last = (i == BL - 1);
          rq.push_back(e);
        end
      end
      if (ADATARDY) begin
        if (pend.size() < FDEPTH || wslot) pend.push_back(ADATA);
        else m_ovf = 1'b1;
      end
      if (wslot && pend.size() > 0) begin
        e.cyc = t; e.addr = m_wptr; e.d = pend.pop_front(); e.last = 1'b0;
        gm[m_wptr] = e.d;
        wq.push_back(e);
        m_wptr = (m_wptr + 1) % RDEPTH;
      end
    end
  end

  // Monitor: compare DUT outputs with the scoreboard away from the clock edge.
  always @(negedge CLK) begin
    if (!RST) begin
      exp_t e;
      chk("wptr", WPTR, m_wptr);
      chk("ovf", OVF, m_ovf);
      chk("busy", BUSY, (t >= bst && t <= bst + BL + 1));
      if (RAM_WE) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wr_cycle", t, e.cyc);
          chk("wr_addr", RAM_ADDR, e.addr);
          chk("wr_data", RAM_WDATA, e.d);
        end
      end
      if (RD_VALID) begin
        if (rq.size() == 0) chk("unexpected_rd_valid", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rd_cycle", t, e.cyc);
          chk("rd_data", RD_DATA, e.d);
          chk("rd_last", RD_LAST, e.last);
        end
      end else begin
        chk("rd_last_idle", RD_LAST, 0);
      end
    end
  end

  task automatic tick(input logic ardy, input logic [DW-1:0] ad, input logic rs);
    ADATARDY = ardy; ADATA = ad; RD_START = rs;
    @(posedge CLK); #1;
    ADATARDY = 1'b0; RD_START = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_rd_data"}, RD_DATA, 0);
    chk({tag, "_rd_valid"}, RD_VALID, 0);
    chk({tag, "_rd_last"}, RD_LAST, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_wptr"}, WPTR, 0);
    chk({tag, "_ovf"}, OVF, 0);
    chk({tag, "_ram_addr"}, RAM_ADDR, 0);
    chk({tag, "_ram_we"}, RAM_WE, 0);
    chk({tag, "_ram_wdata"}, RAM_WDATA, 0);
  endtask

  initial begin
    for (int i = 0; i < RDEPTH; i++) begin
      ram[i] = DW'($urandom);
      gm[i]  = ram[i];
    end
    RST = 1'b1; ADATA = '0; ADATARDY = 1'b0; RD_START = 1'b0;
    repeat (3) @(posedge CLK);
    #1 zero_chk("reset");
    RST = 1'b0;
    idle(2);

    // Spaced single writes 1..5, then a burst from WPTR=5.
    for (int v = 1; v <= 5; v++) begin
      tick(1'b1, DW'(v), 1'b0);
      idle(9);
    end
    chk("wptr_after_5", WPTR, 5);
    tick(1'b0, '0, 1'b1);
    idle(14);

    // Asynchronous reset in the middle of a burst.
    tick(1'b0, '0, 1'b1);
    idle(4);
    #2 RST = 1'b1;
    #1 zero_chk("async_rst");
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    idle(2);

    // WPTR=2 gives a read window that wraps through address 0.
    tick(1'b1, DW'(11), 1'b0);
    tick(1'b1, DW'(22), 1'b0);
    idle(3);
    tick(1'b0, '0, 1'b1);
    idle(14);

    // Four strobes during a burst fit the FIFO; five overflow it.
    tick(1'b0, '0, 1'b1);
    idle(1);
    for (int i = 0; i < 4; i++) tick(1'b1, DW'($urandom), 1'b0);
    idle(12);
    chk("ovf_after_4", OVF, 0);
    tick(1'b0, '0, 1'b1);
    idle(1);
    for (int i = 0; i < 5; i++) tick(1'b1, DW'($urandom), 1'b0);
    idle(14);
    chk("ovf_after_5", OVF, 1);

    // Start during a burst is ignored; start plus strobe reads first.
    tick(1'b0, '0, 1'b1);
    idle(3);
    tick(1'b0, '0, 1'b1);
    idle(12);
    tick(1'b1, DW'(77), 1'b1);
    idle(14);

    // Random traffic, with a reset partway through.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) < 30, DW'($urandom), $urandom_range(0, 99) < 4);
      if (i == 1500) begin
        idle(6);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
      end
    end
    idle(24);
    chk("writes_outstanding", wq.size(), 0);
    chk("reads_outstanding", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
